// File: rtl/bpred_update_scheduler.sv
// bpred_update_scheduler: BHT/PHT port owner, lookup pipe and update RMW.
// BPRED_SCHED_INIT_EN: sweep-initialise both RAMs after reset release.
module bpred_update_scheduler #(
  parameter int IDX_W      = 10,
  parameter int HIST_W     = 10,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       lk_valid,
  input  logic [31:0]                lk_addr,
  output logic                       lk_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       res_valid,
  input  logic [31:0]                res_addr,
  input  logic                       res_taken,
  output logic                       res_ready,
  output logic [$clog2(QDEPTH):0]    q_count,
  output logic                       sched_busy,
  output logic                       bht_en,
  output logic                       bht_we,
  output logic [IDX_W-1:0]           bht_idx,
  output logic [HIST_W-1:0]          bht_wdata,
  input  logic [HIST_W-1:0]          bht_rdata,
  output logic                       pht_en,
  output logic                       pht_we,
  output logic [HIST_W-1:0]          pht_idx,
  output logic [1:0]                 pht_wdata,
  input  logic [1:0]                 pht_rdata
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {U_IDLE, U_RDB, U_RDP, U_WR} ustate_e;
  ustate_e st_q, st_d, ust;

  logic [IDX_W-1:0]  q_idx [QDEPTH];
  logic              q_tk  [QDEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     starve;
  logic [IDX_W-1:0]  u_idx;
  logic              u_tk;
  logic [HIST_W-1:0] u_h;
  logic              lk_v1, lk_v2;
  logic              full, nempty, start, pop, push;
  logic              lk_acc, lk_win;
  logic [1:0]        ctr_n;
  logic              init_act, sw_bht, sw_pht;
  logic [IDX_W-1:0]  sw_bidx;
  logic [HIST_W-1:0] sw_pidx;
  logic              unused_ok;

`ifdef BPRED_SCHED_INIT_EN
  localparam int MW = (IDX_W > HIST_W) ? IDX_W : HIST_W;
  logic [MW-1:0] sw_idx;
  logic          sw_done;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sw_idx  <= '0;
      sw_done <= 1'b0;
    end else if (!sw_done) begin
      sw_idx  <= sw_idx + MW'(1);
      sw_done <= &sw_idx;
    end
  end

  assign init_act = RESET && !sw_done;
  assign sw_bht   = init_act && ((sw_idx >> IDX_W) == '0);
  assign sw_pht   = init_act && ((sw_idx >> HIST_W) == '0);
  assign sw_bidx  = sw_idx[IDX_W-1:0];
  assign sw_pidx  = sw_idx[HIST_W-1:0];
`else
  assign init_act = 1'b0;
  assign sw_bht   = 1'b0;
  assign sw_pht   = 1'b0;
  assign sw_bidx  = '0;
  assign sw_pidx  = '0;
`endif

  assign full   = cnt == CW'(QDEPTH);
  assign nempty = cnt != '0;
  // The start cycle itself performs the BHT read of U_RDB.
  assign start  = RESET && !init_act && st_q == U_IDLE && nempty &&
                  (!lk_valid || starve >= SW'(STARVE_MAX));
  assign ust    = start ? U_RDB : st_q;
  assign pop    = ust == U_RDB;

  assign lk_ready   = RESET && !init_act && ust == U_IDLE;
  assign lk_acc     = lk_valid && lk_ready;
  assign lk_win     = lk_acc && nempty;
  assign res_ready  = RESET && !init_act && !full;
  assign push       = res_valid && res_addr != '0 && RESET &&
                      !init_act && (!full || pop);
  assign q_count    = cnt;
  assign sched_busy = init_act || ust != U_IDLE;
  assign unused_ok  = ^{lk_addr[31:IDX_W+2], lk_addr[1:0]};

  always_comb begin
    ctr_n = pht_rdata;
    if (u_tk) begin
      if (pht_rdata != 2'b11) ctr_n = pht_rdata + 2'd1;
    end else begin
      if (pht_rdata != 2'b00) ctr_n = pht_rdata - 2'd1;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (ust)
      U_IDLE:  st_d = U_IDLE;
      U_RDB:   st_d = U_RDP;
      U_RDP:   st_d = U_WR;
      U_WR:    st_d = U_IDLE;
      default: st_d = U_IDLE;
    endcase
  end

  always_comb begin
    bht_en    = 1'b0;
    bht_we    = 1'b0;
    bht_idx   = '0;
    bht_wdata = '0;
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_idx   = '0;
    pht_wdata = '0;
    if (init_act) begin
      bht_en    = sw_bht;
      bht_we    = sw_bht;
      bht_idx   = sw_bidx;
      pht_en    = sw_pht;
      pht_we    = sw_pht;
      pht_idx   = sw_pidx;
      pht_wdata = 2'b01;
    end else begin
      unique case (1'b1)
        lk_acc: begin
          bht_en  = 1'b1;
          bht_idx = lk_addr[IDX_W+1:2];
        end
        ust == U_RDB: begin
          bht_en  = 1'b1;
          bht_idx = q_idx[rd_ptr];
        end
        ust == U_WR: begin
          bht_en    = 1'b1;
          bht_we    = 1'b1;
          bht_idx   = u_idx;
          bht_wdata = {u_h[HIST_W-2:0], u_tk};
        end
        default: ;
      endcase
      unique case (1'b1)
        lk_v1, ust == U_RDP: begin
          pht_en  = 1'b1;
          pht_idx = bht_rdata;
        end
        ust == U_WR: begin
          pht_en    = 1'b1;
          pht_we    = 1'b1;
          pht_idx   = u_h;
          pht_wdata = ctr_n;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st_q       <= U_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      starve     <= '0;
      u_idx      <= '0;
      u_tk       <= 1'b0;
      u_h        <= '0;
      lk_v1      <= 1'b0;
      lk_v2      <= 1'b0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      st_q <= st_d;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (start) starve <= '0;
      else if (lk_win && starve < SW'(STARVE_MAX))
        starve <= starve + SW'(1);
      if (pop) begin
        u_idx <= q_idx[rd_ptr];
        u_tk  <= q_tk[rd_ptr];
      end
      if (ust == U_RDP) u_h <= bht_rdata;
      lk_v1      <= lk_acc;
      lk_v2      <= lk_v1;
      pred_valid <= lk_v2;
      pred_taken <= lk_v2 & pht_rdata[1];
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_idx[wr_ptr] <= res_addr[IDX_W+1:2];
      q_tk[wr_ptr]  <= res_taken;
    end
  end
endmodule

// File: tb/tb_bpred_update_scheduler.sv
// tb_bpred_update_scheduler: directed checks of lookup pipe, RMW,
// starvation, queue full/drop and mid-RMW reset.
module tb_bpred_update_scheduler;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        lk_valid;
  logic [31:0] lk_addr;
  logic        lk_ready, pred_valid, pred_taken;
  logic        res_valid;
  logic [31:0] res_addr;
  logic        res_taken, res_ready;
  logic [2:0]  q_count;
  logic        sched_busy;
  logic        bht_en, bht_we;
  logic [9:0]  bht_idx, bht_wdata, bht_rdata;
  logic        pht_en, pht_we;
  logic [9:0]  pht_idx;
  logic [1:0]  pht_wdata, pht_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  bpred_update_scheduler dut (
    .CLK(CLK), .RESET(RESET),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_addr(res_addr),
    .res_taken(res_taken), .res_ready(res_ready),
    .q_count(q_count), .sched_busy(sched_busy),
    .bht_en(bht_en), .bht_we(bht_we), .bht_idx(bht_idx),
    .bht_wdata(bht_wdata), .bht_rdata(bht_rdata),
    .pht_en(pht_en), .pht_we(pht_we), .pht_idx(pht_idx),
    .pht_wdata(pht_wdata), .pht_rdata(pht_rdata)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic lv, input logic [31:0] la,
                     input logic rv, input logic [31:0] ra,
                     input logic rt, input logic [9:0] brd,
                     input logic [1:0] prd);
    @(negedge CLK);
    lk_valid  = lv;
    lk_addr   = la;
    res_valid = rv;
    res_addr  = ra;
    res_taken = rt;
    bht_rdata = brd;
    pht_rdata = prd;
    #1;
  endtask

  initial begin
    RESET = 1'b0; lk_valid = 1'b0; lk_addr = '0;
    res_valid = 1'b0; res_addr = '0; res_taken = 1'b0;
    bht_rdata = '0; pht_rdata = '0;

    drv(1, 32'h0040_0010, 1, 32'h10, 1, 0, 0);
    chk("rst_lk_ready", lk_ready, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_bht_en", bht_en, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_pred_valid", pred_valid, 0);
    lk_valid = 1'b0; res_valid = 1'b0;
    RESET = 1'b1;
    #1;
    chk("rel_lk_ready", lk_ready, 1);
    chk("rel_res_ready", res_ready, 1);

    // lookup pipeline
    drv(1, 32'h0040_0010, 0, 0, 0, 0, 0);
    chk("t1_bht_en", bht_en, 1);
    chk("t1_bht_idx", bht_idx, 4);
    chk("t1_bht_we", bht_we, 0);
    chk("t1_pht_en0", pht_en, 0);
    drv(0, 0, 0, 0, 0, 10'h005, 0);
    chk("t1_pht_en", pht_en, 1);
    chk("t1_pht_idx", pht_idx, 5);
    chk("t1_pht_we", pht_we, 0);
    chk("t1_pv_t1", pred_valid, 0);
    drv(0, 0, 0, 0, 0, 0, 2'b10);
    chk("t1_pv_t2", pred_valid, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t1_pv_t3", pred_valid, 1);
    chk("t1_taken", pred_taken, 1);

    // taken update, ctr 2 -> 3
    drv(0, 0, 1, 32'h10, 1, 0, 0);
    chk("t1_pv_t4", pred_valid, 0);
    chk("t2_res_ready", res_ready, 1);
    chk("t2_qc0", q_count, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t2_rdb_busy", sched_busy, 1);
    chk("t2_rdb_lkr", lk_ready, 0);
    chk("t2_rdb_en", bht_en, 1);
    chk("t2_rdb_idx", bht_idx, 4);
    chk("t2_rdb_we", bht_we, 0);
    chk("t2_rdb_qc", q_count, 1);
    drv(0, 0, 0, 0, 0, 10'h005, 0);
    chk("t2_rdp_qc", q_count, 0);
    chk("t2_rdp_pen", pht_en, 1);
    chk("t2_rdp_pidx", pht_idx, 5);
    chk("t2_rdp_pwe", pht_we, 0);
    chk("t2_rdp_ben", bht_en, 0);
    chk("t2_rdp_lkr", lk_ready, 0);
    drv(0, 0, 0, 0, 0, 0, 2'd2);
    chk("t2_wr_bwe", bht_we, 1);
    chk("t2_wr_bidx", bht_idx, 4);
    chk("t2_wr_bwd", bht_wdata, 10'h00B);
    chk("t2_wr_pwe", pht_we, 1);
    chk("t2_wr_pidx", pht_idx, 5);
    chk("t2_wr_pwd", pht_wdata, 3);
    chk("t2_wr_lkr", lk_ready, 0);

    // taken at ctr 3 saturates
    drv(0, 0, 1, 32'h10, 1, 0, 0);
    chk("t2b_busy", sched_busy, 0);
    chk("t2b_lkr", lk_ready, 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t2b_rdb_idx", bht_idx, 4);
    drv(0, 0, 0, 0, 0, 10'h005, 0);
    drv(0, 0, 0, 0, 0, 0, 2'd3);
    chk("t2b_sat_hi", pht_wdata, 3);
    chk("t2b_bwd", bht_wdata, 10'h00B);

    // not-taken at ctr 0 saturates
    drv(0, 0, 1, 32'h3FC, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t2c_rdb_idx", bht_idx, 10'h0FF);
    drv(0, 0, 0, 0, 0, 10'h3FF, 0);
    drv(0, 0, 0, 0, 0, 0, 2'd0);
    chk("t2c_bidx", bht_idx, 10'h0FF);
    chk("t2c_bwd", bht_wdata, 10'h3FE);
    chk("t2c_sat_lo", pht_wdata, 0);

    // res_addr==0 ignored
    drv(0, 0, 1, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t2d_qc", q_count, 0);
    chk("t2d_busy", sched_busy, 0);

    // starvation
    drv(1, 32'h100, 1, 32'h20, 1, 0, 0);
    chk("t3_s0_lkr", lk_ready, 1);
    for (int i = 0; i < 8; i++) begin
      drv(1, 32'h100, 0, 0, 0, 0, 0);
      chk("t3_defer", lk_ready, 1);
    end
    drv(1, 32'h100, 0, 0, 0, 0, 0);
    chk("t3_rdb_lkr", lk_ready, 0);
    chk("t3_rdb_idx", bht_idx, 8);
    chk("t3_rdb_busy", sched_busy, 1);
    chk("t3_overlap_pen", pht_en, 1);
    drv(1, 32'h100, 0, 0, 0, 0, 0);
    chk("t3_rdp_lkr", lk_ready, 0);
    drv(1, 32'h100, 0, 0, 0, 0, 0);
    chk("t3_wr_lkr", lk_ready, 0);
    chk("t3_wr_bwe", bht_we, 1);
    drv(1, 32'h100, 0, 0, 0, 0, 0);
    chk("t3_done_lkr", lk_ready, 1);
    chk("t3_done_qc", q_count, 0);

    // queue full / drop / push+pop
    drv(1, 32'h100, 1, 32'h04, 1, 0, 0);
    chk("t4_p0_rr", res_ready, 1);
    drv(1, 32'h100, 1, 32'h08, 0, 0, 0);
    chk("t4_p1_qc", q_count, 1);
    drv(1, 32'h100, 1, 32'h0C, 1, 0, 0);
    drv(1, 32'h100, 1, 32'h10, 0, 0, 0);
    chk("t4_p3_rr", res_ready, 1);
    chk("t4_p3_qc", q_count, 3);
    drv(1, 32'h100, 1, 32'h14, 1, 0, 0);
    chk("t4_p4_rr", res_ready, 0);
    chk("t4_p4_qc", q_count, 4);
    drv(0, 0, 1, 32'h18, 1, 0, 0);
    chk("t4_p5_qc", q_count, 4);
    chk("t4_p5_rr", res_ready, 0);
    chk("t4_p5_busy", sched_busy, 1);
    chk("t4_p5_head", bht_idx, 1);
    drv(0, 0, 0, 0, 0, 10'h02A, 0);
    chk("t4_p6_qc", q_count, 4);
    chk("t4_p6_pen", pht_en, 1);
    chk("t4_p6_pidx", pht_idx, 10'h02A);

    // reset during U_RDP
    #1 RESET = 1'b0;
    #1;
    chk("t5_bwe", bht_we, 0);
    chk("t5_pwe", pht_we, 0);
    chk("t5_pen", pht_en, 0);
    chk("t5_busy", sched_busy, 0);
    chk("t5_qc", q_count, 0);
    chk("t5_lkr", lk_ready, 0);
    chk("t5_rr", res_ready, 0);
    chk("t5_pv", pred_valid, 0);
    drv(0, 0, 0, 0, 0, 0, 2'd2);
    chk("t5_hold_bwe", bht_we, 0);
    chk("t5_hold_pwe", pht_we, 0);
    RESET = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t5_post_qc", q_count, 0);
    chk("t5_post_lkr", lk_ready, 1);
    chk("t5_post_busy", sched_busy, 0);
    chk("t5_post_bwe", bht_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
